// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the RISC-V boot sequencer.
// The optional checksum field is controlled by the BOOT_CHECKSUM_EN macro, used in riscv_boot_sequencer.sv.
package riscv_boot_pkg;

  // Width of an instruction word and of every image field.
  localparam int WORD_W = 32;

  // Header length in bytes. The data and checksum fields use the same 4-byte framing.
  localparam int HDR_BYTES = 4;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs an incoming byte stream into little-endian 32-bit words.
// Used for the header, data and checksum fields. The word is presented
// combinationally on the edge that accepts its 4th byte, so the owner can
// act on the completed field in that same cycle.
module boot_word_assembler
  import riscv_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]        byte_cnt;
  // Only the first three bytes need storing; the fourth arrives live on byte_data.
  logic [WORD_W-9:0] hold;

  assign word_valid = byte_valid && (byte_cnt == 2'(HDR_BYTES - 1));
  assign word_data  = {byte_data, hold};

  // Byte counter and shift register; bytes shift in from the top so the first byte ends up in [7:0].
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (!reset || clear) begin
      byte_cnt <= '0;
      hold     <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      hold     <= {byte_data, hold[WORD_W-9:8]};
    end
  end

endmodule

// File: rtl/riscv_boot_sequencer.sv
// Boot-time controller: holds the core in reset, loads a length-prefixed
// program image into instruction memory from word 0, then releases the core.
// Optional feature: define BOOT_CHECKSUM_EN to append and verify a 32-bit
// additive checksum after the data words.
module riscv_boot_sequencer
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error
);

  localparam int          REL_W = $clog2(RELEASE_DLY + 1);
  // Largest legal word count, 2^ADDR_W, held one bit wider than a header word.
  localparam logic [32:0] MAX_N = 33'(1) << ADDR_W;

  boot_state_e       state, state_next;
  logic [ADDR_W:0]   word_idx, word_idx_next, idx_inc;
  logic [ADDR_W:0]   n_words, n_words_next;
  logic [REL_W-1:0]  rel_cnt, rel_cnt_next;
  logic              we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [WORD_W-1:0] wdata_next;
  logic              accept;
  logic              asm_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] sum, sum_next;
`endif

  assign accept  = rx_valid && rx_ready;
  assign idx_inc = word_idx + (ADDR_W + 1)'(1);

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Next-state logic plus the next values of the registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_next    = state;
    word_idx_next = word_idx;
    n_words_next  = n_words;
    rel_cnt_next  = rel_cnt;
    we_next       = 1'b0;
    addr_next     = imem_addr;
    wdata_next    = imem_wdata;
    asm_clear     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_next      = sum;
`endif
    case (state)
      ST_HDR: begin
        if (word_valid) begin
          if (word_data == '0 || {1'b0, word_data} > MAX_N) begin
            state_next = ST_ERROR;
          end else begin
            state_next    = ST_DATA;
            n_words_next  = word_data[ADDR_W:0];
            word_idx_next = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_next      = '0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          we_next       = 1'b1;
          addr_next     = word_idx[ADDR_W-1:0];
          wdata_next    = word_data;
          word_idx_next = idx_inc;
`ifdef BOOT_CHECKSUM_EN
          sum_next      = sum + word_data;
`endif
          if (idx_inc == n_words) begin
            rel_cnt_next = '0;
`ifdef BOOT_CHECKSUM_EN
            state_next   = ST_CHK;
`else
            state_next   = ST_RELEASE;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (word_valid) begin
          rel_cnt_next = '0;
          state_next   = (word_data == sum) ? ST_RELEASE : ST_ERROR;
        end
      end
`endif
      ST_RELEASE: begin
        if (rel_cnt == REL_W'(RELEASE_DLY - 1)) begin
          state_next = ST_RUN;
        end else begin
          rel_cnt_next = rel_cnt + REL_W'(1);
        end
      end
      ST_RUN, ST_ERROR: begin
        if (restart) begin
          state_next = ST_HDR;
          asm_clear  = 1'b1;
        end
      end
      default: state_next = ST_HDR;
    endcase
  end

  // State, counters and registered outputs; outputs are derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_HDR;
      word_idx   <= '0;
      n_words    <= '0;
      rel_cnt    <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= '0;
`endif
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      state      <= state_next;
      word_idx   <= word_idx_next;
      n_words    <= n_words_next;
      rel_cnt    <= rel_cnt_next;
`ifdef BOOT_CHECKSUM_EN
      sum        <= sum_next;
`endif
      rx_ready   <= (state_next == ST_HDR) || (state_next == ST_DATA) || (state_next == ST_CHK);
      imem_we    <= we_next;
      imem_addr  <= addr_next;
      imem_wdata <= wdata_next;
      cpu_reset  <= (state_next != ST_RUN);
      boot_done  <= (state_next == ST_RUN);
      boot_error <= (state_next == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Self-checking bench for riscv_boot_sequencer: table of image loads plus
// hand-written sequences for reset mid-load, suppressed strobe and restart.
// Works with or without BOOT_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_riscv_boot_sequencer;

  localparam int ADDR_W      = 4;
  localparam int RELEASE_DLY = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              restart = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              boot_done;
  logic              boot_error;

  int checks = 0;
  int errors = 0;

  // Write scoreboard filled by the monitor below.
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [31:0]       wr_data [0:63];
  int                wr_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] step;
    int          gap;        // idle cycles before each byte; -1 means random 0..3
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs [0:6];

  always #5 clk = ~clk;

  riscv_boot_sequencer #(
    .ADDR_W      (ADDR_W),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .boot_done  (boot_done),
    .boot_error (boot_error)
  );

  // Capture every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    restart  = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Present one byte and hold it until accepted, with a bounded wait.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    int t;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    rx_valid = 1'b0;
    repeat (g) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
  endtask

  task automatic pulse_restart(input string name);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({name, "/rs_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({name, "/rs_boot_done"}, 32'(boot_done), 32'd0);
    check({name, "/rs_boot_error"}, 32'(boot_error), 32'd0);
    check({name, "/rs_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  // Run one complete image load and compare the outcome against the vector.
  task automatic apply_vec(input vec_t v, input bit via_restart);
    logic [31:0] w;
    logic [31:0] sum;
    int          k;
    if (via_restart) pulse_restart(v.name);
    wr_cnt = 0;
    sum    = '0;
    send_word(v.n, v.gap);
    if (v.exp_err) begin
      check({v.name, "/err_boot_error"}, 32'(boot_error), 32'd1);
      check({v.name, "/err_rx_ready"}, 32'(rx_ready), 32'd0);
      check({v.name, "/err_cpu_reset"}, 32'(cpu_reset), 32'd1);
      repeat (3) @(negedge clk);
      check({v.name, "/err_writes"}, 32'(wr_cnt), 32'd0);
      check({v.name, "/err_held"}, 32'(boot_error), 32'd1);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        w   = v.w0 + 32'(i) * v.step;
        sum = sum + w;
        send_word(w, v.gap);
      end
      check({v.name, "/last_we"}, 32'(imem_we), 32'd1);
      check({v.name, "/last_addr"}, 32'(imem_addr), v.n - 32'd1);
      check({v.name, "/last_wdata"}, imem_wdata, w);
      check({v.name, "/release_cpu_reset"}, 32'(cpu_reset), 32'd1);
`ifdef BOOT_CHECKSUM_EN
      send_word(sum, v.gap);
`endif
      k = 0;
      while (cpu_reset === 1'b1 && k < RELEASE_DLY + 8) begin
        @(negedge clk);
        k++;
      end
      check({v.name, "/release_cycles"}, 32'(k), 32'(RELEASE_DLY));
      check({v.name, "/boot_done"}, 32'(boot_done), 32'd1);
      check({v.name, "/boot_error"}, 32'(boot_error), 32'd0);
      check({v.name, "/run_rx_ready"}, 32'(rx_ready), 32'd0);
      check({v.name, "/writes"}, 32'(wr_cnt), 32'(v.exp_writes));
      for (int i = 0; i < v.exp_writes && i < 64; i++) begin
        check({v.name, "/wr_addr"}, 32'(wr_addr[i]), 32'(i));
        check({v.name, "/wr_data"}, wr_data[i], v.w0 + 32'(i) * v.step);
      end
    end
  endtask

  initial begin
    vec_t v;

    // name, n, w0, step, gap, exp_err, exp_writes
    vecs[0] = '{"n2_full",  32'd2,  32'h0000_0013, 32'hDEAD_BEDC, 0,  1'b0, 2};
    vecs[1] = '{"n0",       32'd0,  32'h0,         32'h0,         0,  1'b1, 0};
    vecs[2] = '{"n17",      32'd17, 32'h0,         32'h0,         0,  1'b1, 0};
    vecs[3] = '{"n16_max",  32'd16, 32'hA500_0000, 32'h0000_0011, 0,  1'b0, 16};
    vecs[4] = '{"n3_gaps",  32'd3,  32'h1234_5678, 32'h0101_0101, -1, 1'b0, 3};
    vecs[5] = '{"n1",       32'd1,  32'hFFFF_FFFF, 32'h0,         1,  1'b0, 1};
    vecs[6] = '{"cksum_ok", 32'd2,  32'h0000_0001, 32'h0000_0001, 0,  1'b0, 2};

    // Reset values while reset is held low.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_boot_error", 32'(boot_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Table of loads; each after the first starts with a restart from RUN or ERROR.
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i != 0);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: words 1 and 2 are written, but the sum 3 does not match 4.
    pulse_restart("cksum_bad");
    wr_cnt = 0;
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'd4, 0);
    check("cksum_bad/boot_error", 32'(boot_error), 32'd1);
    check("cksum_bad/cpu_reset", 32'(cpu_reset), 32'd1);
    check("cksum_bad/boot_done", 32'(boot_done), 32'd0);
    repeat (2) @(negedge clk);
    check("cksum_bad/writes", 32'(wr_cnt), 32'd2);
`endif

    // Reset after two bytes of word 1: only word 0 is written.
    do_reset();
    wr_cnt = 0;
    send_word(32'd2, 0);
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/imem_we", 32'(imem_we), 32'd0);
    check("midrst/rx_ready", 32'(rx_ready), 32'd0);
    check("midrst/cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst/writes", 32'(wr_cnt), 32'd1);
    v = '{"after_rst", 32'd2, 32'h1111_1111, 32'h1111_1111, 0, 1'b0, 2};
    apply_vec(v, 1'b0);

    // Reset on the same edge as a word's 4th byte: the pending strobe is dropped.
    do_reset();
    wr_cnt = 0;
    send_word(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    reset    = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    check("suppress/imem_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("suppress/writes", 32'(wr_cnt), 32'd0);
    check("suppress/boot_done", 32'(boot_done), 32'd0);

    // Get to RUN, then restart with rx_valid high: that byte must not be taken.
    v = '{"pre_restart", 32'd1, 32'h0000_0ACE, 32'h0, 0, 1'b0, 1};
    apply_vec(v, 1'b0);
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    check("run_restart/cpu_reset", 32'(cpu_reset), 32'd1);
    check("run_restart/boot_done", 32'(boot_done), 32'd0);
    check("run_restart/rx_ready", 32'(rx_ready), 32'd1);
    v = '{"post_restart", 32'd1, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 1};
    apply_vec(v, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_boot_sequencer.md
# riscv_boot_sequencer

Boot-time controller for the single-cycle RISC-V core. It holds the core in reset, receives a program image as a byte stream over a valid/ready link, and packs it into little-endian 32-bit words. It writes those words into instruction memory from word address 0, then releases the core. It sits between the host/UART receive path, the instruction-memory write port, and the core's reset input.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width; capacity 2^ADDR_W words.
- RELEASE_DLY, 4: cycles spent in RELEASE before core reset deasserts; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; one clock; asserted when 0.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  sequencer accepts a byte this cycle.
- restart  in  1  single-cycle request to reload; honoured only in RUN or ERROR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset to the core; 1 until load completes.
- boot_done  out  1  image loaded and core running.
- boot_error  out  1  load rejected; core held in reset.

## Operation
- Byte transfer happens when rx_valid && rx_ready. rx_ready = 1 only in HDR, DATA and CHK. rx_data is ignored otherwise.
- Image format (all fields little-endian):
  - 4-byte word count N.
  - N data words.
  - 4-byte checksum, only with BOOT_CHECKSUM_EN.
- State machine:
  - HDR: collect 4 bytes into N.
    - N == 0 or N > 2^ADDR_W → ERROR.
    - Otherwise → DATA, with word index 0 and running sum 0.
  - DATA: assemble 4 bytes per word, first byte in [7:0].
    - Completed word is written at imem_addr = word index. Word index and sum advance.
    - After the Nth word → CHK if BOOT_CHECKSUM_EN, else RELEASE.
  - CHK: collect 4 bytes.
    - Equal to the running sum → RELEASE.
    - Otherwise → ERROR.
  - RELEASE: count RELEASE_DLY cycles, then → RUN.
  - RUN: cpu_reset = 0, boot_done = 1.
  - ERROR: boot_error = 1, cpu_reset = 1.
- restart in RUN or ERROR → HDR. cpu_reset goes to 1, and boot_done/boot_error clear on the same edge. restart in any other state is ignored.
- Arithmetic: word index is ADDR_W+1 bits wide so N = 2^ADDR_W is representable. Running sum is mod 2^32.
- Memory contents are never cleared by the sequencer. Words beyond N are left as they were.

## Timing
- Reset values:
  - State HDR, all counters 0.
  - rx_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_reset = 1, boot_done = 0, boot_error = 0.
- First cycle after reset deasserts: rx_ready = 1.
- All outputs are registered.
- imem_we pulses exactly one cycle, starting the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are valid in that same cycle.
- A byte may be accepted every cycle. Full-rate input therefore causes no stall: at most one write occurs per 4 transfers.
- State transitions take effect on the edge of the final accepted byte of a field:
  - Last header byte accepted → DATA next cycle, or ERROR next cycle.
  - Last byte of word N accepted → next state next cycle. The final imem_we occurs in that first cycle of CHK/RELEASE.
  - Checksum compare happens on the edge of its 4th byte. The result state appears next cycle.
- RELEASE lasts exactly RELEASE_DLY cycles. cpu_reset falls and boot_done rises together on entry to RUN.
- Reset mid-load returns to HDR and drops any partial word. A write strobe pending on that edge is suppressed.
- restart and reset on the same edge: reset wins.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - CHK state and the 32-bit running sum are compiled in.
  - A mismatch → ERROR.
- BOOT_CHECKSUM_EN not defined:
  - No CHK state and no sum register.
  - DATA goes straight to RELEASE.
  - boot_error is raised only by a bad header count.

## Structure
- Shared package riscv_boot_pkg holds:
  - State enum (HDR, DATA, CHK, RELEASE, RUN, ERROR).
  - Header length constant (4 bytes) and word width (32).
- One sub-module: boot_word_assembler.
  - 2-bit byte counter plus 32-bit shift/insert register.
  - Emits word_valid with the completed word.
  - Used for the header, data and checksum fields.
  - Cleared by reset or by the top block on field change.

## Test plan
- Load N=2 with data words 0x00000013 and 0xDEADBEEF at full rate, no checksum:
  - Writes at addr 0 then addr 1 with the correct wdata.
  - cpu_reset falls RELEASE_DLY cycles after the last write cycle.
  - boot_done = 1.
- Header N=0, then N=2^ADDR_W+1 after restart:
  - boot_error = 1 in both cases, with no imem_we and cpu_reset = 1.
  - rx_ready = 0 in ERROR.
- With BOOT_CHECKSUM_EN, words 0x1 and 0x2:
  - Checksum 0x3 → RUN.
  - After restart, checksum 0x4 → ERROR.
- Insert random rx_valid gaps inside a word:
  - The same words land at the same addresses.
  - Exactly one imem_we per word.
- Assert reset after 2 bytes of word 1:
  - No write occurs for the partial word.
  - The load restarts from HDR and then succeeds from address 0.
- In RUN, pulse restart with rx_valid high:
  - No byte accepted on that cycle.
  - cpu_reset = 1 and boot_done = 0 next cycle, with rx_ready = 1.
